rtl_ram_dp: RTL

RTL_RAM_DP -- requirements
Module: rtl_ram_dp

---
 rtl/rtl_ram_dp.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rtl_ram_dp.sv
// Dual-port single-clock RAM with a clear sweep after reset.
//
// Port A is an asynchronous-SRAM-style interface (CS_N/OE_N/WR_N with a
// bidirectional data bus). Port B is a request/acknowledge interface.
// READY is low during reset and the clear sweep, and only then.
//
// Ports:
//   CLK      clock, all logic on the rising edge
//   RST      asynchronous active-high reset
//   A        port A address
//   DIO      port A data, driven only while reading (OE_N, CS_N low, WR_N high)
//   CS_N     port A chip select, active low
//   OE_N     port A output enable, active low
//   WR_N     port A write enable, active low
//   B_REQ    port B request
//   B_WE     port B write (1) / read (0)
//   B_ADDR   port B address
//   B_WDATA  port B write data
//   B_ACK    port B completion pulse, 1+OUT_REG cycles after acceptance
//   B_RDATA  port B read data, valid with the read ACK, held until the next one
//   READY    memory usable
`timescale 1ns/1ps
module rtl_ram_dp #(
  parameter int unsigned           ADDR_WIDTH     = 15,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           DEPTH          = 1 << ADDR_WIDTH,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    OUT_REG        = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  inout  wire  [DATA_WIDTH-1:0] DIO,
  input  logic                  CS_N,
  input  logic                  OE_N,
  input  logic                  WR_N,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_WDATA,
  output logic                  B_ACK,
  output logic [DATA_WIDTH-1:0] B_RDATA,
  output logic                  READY
);

  localparam logic [ADDR_WIDTH-1:0] ClrLast = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {StReset, StClear, StRun} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    ready_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [DATA_WIDTH-1:0]   a_rd_q, a_rd2_q;
  logic                    b_ack_q, b_ack2_q;
  logic                    b_rd_q;
  logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata2_q;

  logic                    a_in_range, b_in_range;
  logic                    a_we, a_re, b_acc, b_we, b_re;
  logic                    clr_we;
  logic [DATA_WIDTH-1:0]   a_mem, b_mem, a_dout;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StReset: begin
        clr_addr_d = '0;
        state_d    = CLEAR_ON_RESET ? StClear : StRun;
      end
      StClear: begin
        if (clr_addr_q == ClrLast) begin
          state_d = StRun;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StReset;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign a_in_range = 32'(A) < DEPTH;
  assign b_in_range = 32'(B_ADDR) < DEPTH;

  assign clr_we = (state_q == StClear);
  assign a_we   = ready_q & ~CS_N & ~WR_N & a_in_range;
  assign a_re   = ready_q & ~CS_N & ~OE_N;
  assign b_acc  = ready_q & B_REQ;
  assign b_we   = b_acc & B_WE & b_in_range;
  assign b_re   = b_acc & ~B_WE;

  // Addresses beyond DEPTH read as the clear value.
  assign a_mem = a_in_range ? mem_q[A]      : CLEAR_VALUE;
  assign b_mem = b_in_range ? mem_q[B_ADDR] : CLEAR_VALUE;

  // ---------------------------------------------------------------------------
  // Storage: no reset, only the clear sweep initialises it.
  // Port A is written last so it wins a same-address collision.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[clr_addr_q] <= CLEAR_VALUE;
    end else begin
      if (b_we) mem_q[B_ADDR] <= B_WDATA;
      if (a_we) mem_q[A]      <= DIO;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StReset;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      a_rd_q     <= '0;
      a_rd2_q    <= '0;
      b_ack_q    <= 1'b0;
      b_ack2_q   <= 1'b0;
      b_rd_q     <= 1'b0;
      b_rdata_q  <= '0;
      b_rdata2_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= (state_d == StRun);
      if (a_re) a_rd_q <= a_mem;
      a_rd2_q    <= a_rd_q;
      b_ack_q    <= b_acc;
      b_rd_q     <= b_re;
      if (b_re) b_rdata_q <= b_mem;
      b_ack2_q   <= b_ack_q;
      // Second stage only follows completed reads so write ACKs leave it alone.
      if (b_ack_q && b_rd_q) b_rdata2_q <= b_rdata_q;
    end
  end

  assign a_dout  = OUT_REG ? a_rd2_q    : a_rd_q;
  assign B_ACK   = OUT_REG ? b_ack2_q   : b_ack_q;
  assign B_RDATA = OUT_REG ? b_rdata2_q : b_rdata_q;
  assign READY   = ready_q;

  assign DIO = (~OE_N & ~CS_N & WR_N) ? a_dout : {DATA_WIDTH{1'bz}};

endmodule
